// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and helpers for the data-memory responder
package dmem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    // Byte enables for a store: all four lanes for a word, one lane for a byte
    function automatic logic [3:0] laneEnable(input logic word, input logic [1:0] lane);
        laneEnable = word ? 4'b1111 : (4'b0001 << lane);
    endfunction

    // Load result: whole word, or the little-endian lane sign-extended to 32 bits
    function automatic logic [31:0] loadExtract(input logic word, input logic [1:0] lane,
                                                input logic [31:0] data);
        logic [7:0] b;
        case (lane)
            LANE0:   b = data[7:0];
            LANE1:   b = data[15:8];
            LANE2:   b = data[23:16];
            default: b = data[31:24];
        endcase
        loadExtract = word ? data : {{24{b[7]}}, b};
    endfunction

    // Misaligned word access or word index beyond the array
    function automatic logic accessErr(input logic word, input logic [31:0] addr,
                                       input int unsigned depth);
        accessErr = (word && (addr[1:0] != 2'b00)) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with combinational read and byte-enabled synchronous write
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clock,
    input  logic [AW-1:0] rdIndex,
    output logic [31:0]   rdData,
    input  logic          we,
    input  logic [AW-1:0] wrIndex,
    input  logic [3:0]    wrBe,
    input  logic [31:0]   wrData
);

    // Contents survive reset on purpose; only the responder control state is cleared
    logic [31:0] mem [DEPTH_WORDS];

    assign rdData = mem[rdIndex];

    // Write only the enabled byte lanes of the addressed word
    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wrBe[b]) begin
                    mem[wrIndex][8*b +: 8] <= wrData[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with fixed access latency and pipeline stall
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_word,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    stateT             state;
    logic [CNT_W-1:0]  cnt;
    logic              capWrite;
    logic              capWord;
    logic [31:0]       capAddr;
    logic [31:0]       capWdata;

    logic              reqReadyQ;
    logic              respValidQ;
    logic [31:0]       respRdataQ;
    logic              respErrQ;

    logic [AW-1:0]     rdIndex;
    logic [31:0]       rdData;
    logic              newErr;
    logic              capErr;
    logic [31:0]       newResult;
    logic [31:0]       capResult;
    logic              memWe;
    logic [3:0]        memBe;
    logic [31:0]       memWdata;

    // With LATENCY=1 the response is formed in the acceptance cycle, so read from the live request
    always_comb begin
        rdIndex   = (state == IDLE) ? req_addr[AW+1:2] : capAddr[AW+1:2];
        newErr    = accessErr(req_word, req_addr, $unsigned(DEPTH_WORDS));
        capErr    = accessErr(capWord, capAddr, $unsigned(DEPTH_WORDS));
        newResult = (newErr || req_write) ? 32'd0 : loadExtract(req_word, req_addr[1:0], rdData);
        capResult = (capErr || capWrite) ? 32'd0 : loadExtract(capWord, capAddr[1:0], rdData);
    end

    // Store commits at the edge that ends the response cycle, never on an erroring request
    always_comb begin
        memWe    = (state == RESP) && capWrite && !respErrQ;
        memBe    = laneEnable(capWord, capAddr[1:0]);
        memWdata = capWord ? capWdata : {4{capWdata[7:0]}};
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clock   (clock),
        .rdIndex (rdIndex),
        .rdData  (rdData),
        .we      (memWe),
        .wrIndex (capAddr[AW+1:2]),
        .wrBe    (memBe),
        .wrData  (memWdata)
    );

    // Request FSM: capture on acceptance, count down the latency, pulse one response
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            capWrite   <= 1'b0;
            capWord    <= 1'b0;
            capAddr    <= 32'd0;
            capWdata   <= 32'd0;
            reqReadyQ  <= 1'b1;
            respValidQ <= 1'b0;
            respRdataQ <= 32'd0;
            respErrQ   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && reqReadyQ) begin
                        capWrite  <= req_write;
                        capWord   <= req_word;
                        capAddr   <= req_addr;
                        capWdata  <= req_wdata;
                        reqReadyQ <= 1'b0;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            respValidQ <= 1'b1;
                            respRdataQ <= newResult;
                            respErrQ   <= newErr;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state      <= RESP;
                        respValidQ <= 1'b1;
                        respRdataQ <= capResult;
                        respErrQ   <= capErr;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    reqReadyQ  <= 1'b1;
                    respValidQ <= 1'b0;
                    respRdataQ <= 32'd0;
                    respErrQ   <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    reqReadyQ  <= 1'b1;
                    respValidQ <= 1'b0;
                    respRdataQ <= 32'd0;
                    respErrQ   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = reqReadyQ;
    assign resp_valid = respValidQ;
    assign resp_rdata = respRdataQ;
    assign resp_err   = respErrQ;
    assign stall      = req_valid && !respValidQ;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed table-driven bench for dmem_responder
module tb_dmem_responder;

    logic        clock;
    logic        rst;

    logic        reqValid, reqReady, reqWrite, reqWord;
    logic [31:0] reqAddr, reqWdata;
    logic        respValid, respErr, stall;
    logic [31:0] respRdata;

    logic        r1Valid, r1Ready, r1Write, r1Word;
    logic [31:0] r1Addr, r1Wdata;
    logic        r1RespValid, r1RespErr, r1Stall;
    logic [31:0] r1RespRdata;

    int nTests = 0;
    int nFail  = 0;

    typedef struct {
        logic        write;
        logic        word;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
    } vecT;

    vecT vecs[17];

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clock      (clock),
        .rst        (rst),
        .req_valid  (reqValid),
        .req_ready  (reqReady),
        .req_write  (reqWrite),
        .req_word   (reqWord),
        .req_addr   (reqAddr),
        .req_wdata  (reqWdata),
        .resp_valid (respValid),
        .resp_rdata (respRdata),
        .resp_err   (respErr),
        .stall      (stall)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clock      (clock),
        .rst        (rst),
        .req_valid  (r1Valid),
        .req_ready  (r1Ready),
        .req_write  (r1Write),
        .req_word   (r1Word),
        .req_addr   (r1Addr),
        .req_wdata  (r1Wdata),
        .resp_valid (r1RespValid),
        .resp_rdata (r1RespRdata),
        .resp_err   (r1RespErr),
        .stall      (r1Stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One request on the LATENCY=2 instance; fields are scrambled after acceptance
    task automatic doVec(input vecT v, input string tag);
        int lat = 0;
        int stallCnt = 0;
        logic [31:0] gotData = 32'd0;
        logic gotErr = 1'b0;
        @(negedge clock);
        reqValid = 1'b1;
        reqWrite = v.write;
        reqWord  = v.word;
        reqAddr  = v.addr;
        reqWdata = v.wdata;
        #1;
        check({tag, " ready_at_issue"}, {31'd0, reqReady}, 32'd1);
        if (stall) stallCnt++;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1;
            reqAddr  = v.addr ^ 32'h0000_0004;
            reqWdata = ~v.wdata;
            reqWord  = ~v.word;
            @(negedge clock);
            if (respValid) begin
                lat     = k;
                gotData = respRdata;
                gotErr  = respErr;
                reqValid = 1'b0;
                break;
            end
            if (stall) stallCnt++;
        end
        reqValid = 1'b0;
        check({tag, " latency"}, lat, 32'd2);
        check({tag, " rdata"}, gotData, v.expRdata);
        check({tag, " err"}, {31'd0, gotErr}, {31'd0, v.expErr});
        check({tag, " stall_cycles"}, stallCnt, 32'd2);
    endtask

    initial begin
        vecT rv;
        logic [5:0] expRv, expRdy, expStall;
        int seen;

        vecs[0]  = '{1'b1, 1'b1, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'h020, 32'h11223344, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h022, 32'h123456AA, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h020, 32'h0,        32'h11AA3344, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h022, 32'h0,        32'hFFFFFFAA, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h020, 32'h0,        32'h00000044, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'h021, 32'hCAFEBABE, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 1'b1, 32'h020, 32'h0,        32'h11AA3344, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h400, 32'h0,        32'h0,        1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h023, 32'h0,        32'h00000011, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h021, 32'h0,        32'h00000033, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 32'h3FC, 32'h80000001, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h3FC, 32'h0,        32'h80000001, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 32'h3FF, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1};
        vecs[16] = '{1'b0, 1'b1, 32'h012, 32'h0,        32'h0,        1'b1};

        rst = 1'b0;
        reqValid = 1'b0; reqWrite = 1'b0; reqWord = 1'b0; reqAddr = 32'd0; reqWdata = 32'd0;
        r1Valid  = 1'b0; r1Write  = 1'b0; r1Word  = 1'b0; r1Addr  = 32'd0; r1Wdata  = 32'd0;

        repeat (3) @(negedge clock);
        check("reset req_ready", {31'd0, reqReady}, 32'd1);
        check("reset resp_valid", {31'd0, respValid}, 32'd0);
        check("reset resp_rdata", respRdata, 32'd0);
        check("reset resp_err", {31'd0, respErr}, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 17; i++) begin
            doVec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during the wait cycle of a byte store to 0x20
        @(negedge clock);
        reqValid = 1'b1; reqWrite = 1'b1; reqWord = 1'b0; reqAddr = 32'h20; reqWdata = 32'h55;
        #1;
        check("midrst ready_at_issue", {31'd0, reqReady}, 32'd1);
        @(posedge clock);
        #1;
        rst = 1'b0;
        reqValid = 1'b0;
        #1;
        check("midrst req_ready", {31'd0, reqReady}, 32'd1);
        check("midrst resp_valid", {31'd0, respValid}, 32'd0);
        @(negedge clock);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (respValid) seen++;
        end
        check("midrst no_response", seen, 32'd0);
        rv = '{1'b0, 1'b1, 32'h020, 32'h0, 32'h11AA3344, 1'b0};
        doVec(rv, "midrst reload");

        // LATENCY=1 instance: seed a word, then two loads with req_valid held high
        @(negedge clock);
        r1Valid = 1'b1; r1Write = 1'b1; r1Word = 1'b1; r1Addr = 32'h8; r1Wdata = 32'hCAFEF00D;
        @(negedge clock);
        check("lat1 store resp_valid", {31'd0, r1RespValid}, 32'd1);
        check("lat1 store err", {31'd0, r1RespErr}, 32'd0);
        r1Valid = 1'b0;
        @(negedge clock);
        r1Valid = 1'b1; r1Write = 1'b0; r1Word = 1'b1; r1Addr = 32'h8; r1Wdata = 32'd0;
        expRv    = 6'b001010;
        expRdy   = 6'b110101;
        expStall = 6'b000101;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("b2b c%0d resp_valid", c), {31'd0, r1RespValid}, {31'd0, expRv[c]});
            check($sformatf("b2b c%0d req_ready", c), {31'd0, r1Ready}, {31'd0, expRdy[c]});
            check($sformatf("b2b c%0d stall", c), {31'd0, r1Stall}, {31'd0, expStall[c]});
            if (expRv[c]) begin
                check($sformatf("b2b c%0d rdata", c), r1RespRdata, 32'hCAFEF00D);
            end
            if (c == 3) r1Valid = 1'b0;
            @(negedge clock);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the load/store requests the memory stage issues.
- Accepts one request at a time over a valid/ready handshake and models a configurable access latency.
- Returns read data or a write acknowledge, plus an error flag, one cycle per request.
- Drives a stall signal that freezes the pipeline flip-flops while an access is outstanding.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the storage array.
- LATENCY, 2, cycles from request acceptance to the response cycle; legal range 1..15.

Ports:
- clock  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  memory stage presents a request (memRead or memWrite).
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_word  in  1  1 = 32-bit access, 0 = byte access.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte stores use bits 7:0.
- resp_valid  out  1  one-cycle pulse; response fields are valid.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned word access or address out of range.
- stall  out  1  pipeline hold request: req_valid & ~resp_valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Captured request registers and the latency counter clear.
  - The storage array is not cleared.
- Reset asserted mid-access: any pending store is discarded and no response is produced.
- FSM IDLE:
  - req_ready=1.
  - Acceptance is req_valid & req_ready at a rising edge; on acceptance, write/word/addr/wdata are captured.
  - If LATENCY=1, go to RESP; otherwise go to WAIT with cnt=LATENCY-1.
- FSM WAIT:
  - req_ready=0.
  - cnt decrements each cycle; when cnt=1, go to RESP.
- FSM RESP:
  - resp_valid=1 and req_ready=0 for exactly one cycle, then IDLE.
  - A new request can be accepted no earlier than the cycle after RESP.
- Latency: a request accepted in cycle T gets resp_valid in cycle T+LATENCY.
- Input changes: changes to req_* after acceptance are ignored; the captured copy is used.
- Error check, performed on the captured request:
  - err = (word & addr[1:0]!=0) | (addr[31:2] >= DEPTH_WORDS).
  - On error: no array write, resp_rdata=0, resp_err=1.
- Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0, 3 selects bits 31:24.
- Word load: resp_rdata = mem[addr[31:2]].
- Byte load: selected lane, sign-extended to 32 bits.
- Store timing: the array is written at the rising edge ending the RESP cycle, so a load accepted afterwards sees the new data.
- Word store: all 4 lanes written.
- Byte store: only the selected lane written, from wdata[7:0]; other lanes preserved.
- stall is combinational: high from the cycle req_valid rises until (but not including) the resp_valid cycle. It is low in the resp_valid cycle so the pipeline advances exactly once.
- Flushes: a flush of the requesting instruction does not cancel an accepted access; the response still occurs.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - lane constants LANE0..LANE3;
  - CNT_W=4.
- Sub-module dmem_array provides the storage: combinational read, synchronous write with 4-bit byte-enable.
- FSM, error check, lane extraction and sign extension stay in dmem_responder.

Test Plan:
- Word round trip (LATENCY=2):
  - Store word 0xDEADBEEF to 0x10, accepted cycle 5 -> resp_valid cycle 7, err=0.
  - Load word 0x10 -> resp_rdata=0xDEADBEEF two cycles after acceptance.
  - stall high exactly cycles 5-6 of the store.
- Byte lane: store word 0x11223344 to 0x20, then store byte 0xAA to 0x22 -> word load of 0x20 returns 0x11AA3344.
- Sign extension:
  - Byte load of 0x22 after the previous test -> 0xFFFFFFAA.
  - Byte load of 0x20 -> 0x00000044.
- Errors, each with resp_err=1 and resp_rdata=0:
  - Word store to 0x21: memory unchanged (a later load of 0x20 still returns 0x11AA3344).
  - Word load of 0x400 with DEPTH_WORDS=256: error response.
- Reset mid-access: store 0x55 accepted, drop rst in the WAIT cycle -> no resp_valid, req_ready=1 immediately; a subsequent load of that address returns the old value.
- Back-to-back with LATENCY=1: two loads held on req_valid continuously -> resp_valid at cycles T+1 and T+3, req_ready low in each RESP cycle, no double acceptance.
